// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - state encoding, segment table and sizing helper for the scan driver
package seg_pkg;

  localparam logic [1:0] ST_OFF = 2'd0;
  localparam logic [1:0] ST_ON  = 2'd1;
  localparam logic [1:0] ST_GAP = 2'd2;

  // Active-high gfedcba patterns, entry n is hex digit n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [7:0] SEG_OFF = 8'h00;

  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; (1 << i) < value; i++) begin
      bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - load handshake carrying one packed hex word and its decimal points
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;
  logic [NUM_DIGITS-1:0]   load_dp;

  modport master (output load_valid, load_data, load_dp, input load_ready);
  modport slave  (input load_valid, load_data, load_dp, output load_ready);
endinterface

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - nibble to active-high gfedcba pattern, with forced blank
module seg7_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  assign o_seg = i_blank ? 7'h00 : HEX_SEG[i_nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - double-buffered multiplexed seven-segment scanner with dead-time gap
// Optional leading-zero blanking: SEG_LEADING_ZERO_BLANK_EN
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int PRESCALE       = 50000,
  parameter int DEAD_CYCLES    = 2,
  parameter int ACTIVE_LOW_SEG = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  seg_scan_driver_if.slave      load_if,
  output logic [NUM_DIGITS-1:0] o_digit_sel,
  output logic [7:0]            o_seg,
  output logic                  o_frame_done
);

  localparam int DW   = 4 * NUM_DIGITS;
  localparam int IW   = clog2(NUM_DIGITS);
  localparam int CMAX = (PRESCALE > DEAD_CYCLES) ? PRESCALE : DEAD_CYCLES;
  localparam int CW   = clog2(CMAX + 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = (ACTIVE_LOW_SEG != 0) ? '1 : '0;
  localparam logic [7:0] SEG_IDLE = (ACTIVE_LOW_SEG != 0) ? ~SEG_OFF : SEG_OFF;

  logic [1:0]            r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic [DW-1:0]         r_act_data, w_act_data_nxt, r_pend_data, w_pend_data_nxt;
  logic [NUM_DIGITS-1:0] r_act_dp, w_act_dp_nxt, r_pend_dp, w_pend_dp_nxt;
  logic                  r_pend_valid, w_pend_valid_nxt;
  logic [NUM_DIGITS-1:0] r_digit_sel, w_digit_sel_nxt;
  logic [7:0]            r_seg, w_seg_nxt;
  logic                  r_frame_done, w_frame_done_nxt;
  logic                  w_xfer, w_blank;
  logic [3:0]            w_nibble;
  logic [6:0]            w_hex;

  assign w_xfer             = load_if.load_valid && load_if.load_ready;
  assign load_if.load_ready = !r_pend_valid;
  assign o_digit_sel        = r_digit_sel;
  assign o_seg              = r_seg;
  assign o_frame_done       = r_frame_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    if (!i_enable) begin
      w_state_nxt = ST_OFF;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt = ST_ON;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
        ST_ON: begin
          if (r_cnt == PRE_LAST) begin
            w_cnt_nxt = '0;
            if (DEAD_CYCLES == 0) w_idx_nxt = r_idx + 1'b1;
            else                  w_state_nxt = ST_GAP;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            w_state_nxt = ST_ON;
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // r_frame_done marks the boundary cycle itself, so it doubles as the commit strobe
  always_comb begin
    w_act_data_nxt   = r_act_data;
    w_act_dp_nxt     = r_act_dp;
    w_pend_data_nxt  = r_pend_data;
    w_pend_dp_nxt    = r_pend_dp;
    w_pend_valid_nxt = r_pend_valid;
    if (r_state == ST_OFF || r_frame_done) begin
      if (r_pend_valid) begin
        w_act_data_nxt   = r_pend_data;
        w_act_dp_nxt     = r_pend_dp;
        w_pend_valid_nxt = 1'b0;
      end else if (w_xfer) begin
        w_act_data_nxt = load_if.load_data;
        w_act_dp_nxt   = load_if.load_dp;
      end
    end else if (w_xfer) begin
      w_pend_data_nxt  = load_if.load_data;
      w_pend_dp_nxt    = load_if.load_dp;
      w_pend_valid_nxt = 1'b1;
    end
  end

  assign w_nibble = w_act_data_nxt[4*w_idx_nxt +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
  assign w_blank = (w_idx_nxt != '0) && ((w_act_data_nxt >> (4*w_idx_nxt)) == '0);
`else
  assign w_blank = 1'b0;
`endif

  seg7_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .i_blank  (w_blank),
    .o_seg    (w_hex)
  );

  // Outputs are computed from next-state values so the registers line up with r_state
  always_comb begin
    w_digit_sel_nxt = SEL_IDLE;
    w_seg_nxt       = SEG_IDLE;
    if (w_state_nxt == ST_ON) begin
      w_digit_sel_nxt = (NUM_DIGITS'(1) << w_idx_nxt) ^ SEL_IDLE;
      w_seg_nxt       = {w_act_dp_nxt[w_idx_nxt], w_hex} ^ SEG_IDLE;
    end
    if (DEAD_CYCLES == 0)
      w_frame_done_nxt = (w_state_nxt == ST_ON) && (w_idx_nxt == IDX_LAST) && (w_cnt_nxt == PRE_LAST);
    else
      w_frame_done_nxt = (w_state_nxt == ST_GAP) && (w_idx_nxt == IDX_LAST) && (w_cnt_nxt == GAP_LAST);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_act_data   <= '0;
      r_act_dp     <= '0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_digit_sel  <= SEL_IDLE;
      r_seg        <= SEG_IDLE;
      r_frame_done <= 1'b0;
    end else begin
      r_act_data   <= w_act_data_nxt;
      r_act_dp     <= w_act_dp_nxt;
      r_pend_data  <= w_pend_data_nxt;
      r_pend_dp    <= w_pend_dp_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_digit_sel  <= w_digit_sel_nxt;
      r_seg        <= w_seg_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - scoreboard bench for seg_scan_driver (PRESCALE=4, DEAD_CYCLES=1)
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] digit_sel;
  logic [7:0] seg;
  logic       frame_done;
  int         total = 0;
  int         bad = 0;
  logic [15:0] exp_q[$];

  // Expected active-low seg bytes per word, digit 7 in the top byte
  localparam logic [63:0] W1_SEG = 64'hF9A4B0999282F880;
  localparam logic [63:0] W2_SEG = 64'h8888888888888888;
  localparam logic [63:0] W3_SEG = 64'h908883C6A1868E40;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [63:0] W4_SEG = 64'hFFFFFFFFFFFFFF8E;
  localparam logic [63:0] W5_SEG = 64'hFFFFFFFFFFF9C092;
`else
  localparam logic [63:0] W4_SEG = 64'hC0C0C0C0C0C0C08E;
  localparam logic [63:0] W5_SEG = 64'hC0C0C0C0C0F9C092;
`endif

  seg_scan_driver_if #(.NUM_DIGITS(8)) u_if ();

  seg_scan_driver #(
    .NUM_DIGITS(8), .PRESCALE(4), .DEAD_CYCLES(1), .ACTIVE_LOW_SEG(1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .load_if      (u_if),
    .o_digit_sel  (digit_sel),
    .o_seg        (seg),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [63:0] segs, input int first, input int last);
    logic [7:0] sel;
    for (int i = first; i <= last; i++) begin
      sel = ~(8'h01 << i);
      exp_q.push_back({sel, segs[8*i +: 8]});
    end
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_done && n < 200);
    if (!frame_done) check("frame_done_timeout", 32'(frame_done), 32'd1);
  endtask

  task automatic offer(input logic [31:0] data, input logic [7:0] dp);
    u_if.load_valid = 1'b1;
    u_if.load_data  = data;
    u_if.load_dp    = dp;
  endtask

  // Monitor: one pop per lit slot, segment stability while lit, blank gaps
  logic [7:0]  prev_sel = 8'hFF;
  logic [7:0]  last_lit = 8'hFF;
  logic [15:0] cur = 16'h0;
  logic        have_cur = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (digit_sel != 8'hFF) begin
        if (prev_sel == 8'hFF) begin
          if (exp_q.size() == 0) begin
            check("slot_unexpected", 32'(digit_sel), 32'hFF);
            have_cur = 1'b0;
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            check("slot_sel", 32'(digit_sel), 32'(cur[15:8]));
          end
        end
        if (have_cur) check("slot_seg", 32'(seg), 32'(cur[7:0]));
        last_lit = digit_sel;
      end else begin
        check("gap_seg", 32'(seg), 32'hFF);
      end
      if (frame_done) check("frame_done_after_digit7", 32'(last_lit), 32'h7F);
      prev_sel = digit_sel;
    end else begin
      prev_sel = 8'hFF;
    end
  end

  initial begin
    int   n;
    logic seen;
    u_if.load_valid = 1'b0;
    u_if.load_data  = '0;
    u_if.load_dp    = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_sel", 32'(digit_sel), 32'hFF);
    check("rst_ready", 32'(u_if.load_ready), 32'd1);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    offer(32'h12345678, 8'h00);
    tick();
    u_if.load_valid = 1'b0;
    check("ready_after_off_load", 32'(u_if.load_ready), 32'd1);

    push_frame(W1_SEG, 0, 7);
    push_frame(W1_SEG, 0, 7);
    push_frame(W1_SEG, 0, 7);
    push_frame(W2_SEG, 0, 7);
    push_frame(W3_SEG, 0, 7);
    push_frame(W4_SEG, 0, 3);
    push_frame(W1_SEG, 0, 7);
    push_frame(W1_SEG, 0, 1);

    enable = 1'b1;
    wait_fd(n);
    wait_fd(n);
    check("frame_period", 32'(n), 32'd40);

    repeat (10) tick();
    offer(32'hAAAAAAAA, 8'h00);
    tick();
    check("ready_drop_mid_frame", 32'(u_if.load_ready), 32'd0);
    offer(32'h9ABCDEF0, 8'h01);
    wait_fd(n);
    check("ready_low_at_boundary", 32'(u_if.load_ready), 32'd0);
    tick();
    check("ready_after_commit", 32'(u_if.load_ready), 32'd1);
    tick();
    check("ready_second_accept", 32'(u_if.load_ready), 32'd0);
    u_if.load_valid = 1'b0;
    wait_fd(n);
    tick();
    check("ready_after_commit2", 32'(u_if.load_ready), 32'd1);

    wait_fd(n);
    offer(32'h0000000F, 8'h00);
    check("ready_bypass_before", 32'(u_if.load_ready), 32'd1);
    tick();
    u_if.load_valid = 1'b0;
    check("ready_bypass_after", 32'(u_if.load_ready), 32'd1);

    repeat (2) tick();
    offer(32'h12345678, 8'h00);
    tick();
    u_if.load_valid = 1'b0;
    check("ready_pending_mid", 32'(u_if.load_ready), 32'd0);
    repeat (13) tick();
    enable = 1'b0;
    tick();
    check("off_sel", 32'(digit_sel), 32'hFF);
    check("off_seg", 32'(seg), 32'hFF);
    seen = 1'b0;
    repeat (50) begin
      tick();
      seen = seen | frame_done;
    end
    check("no_frame_done_when_off", 32'(seen), 32'd0);
    check("ready_off_commit", 32'(u_if.load_ready), 32'd1);

    enable = 1'b1;
    wait_fd(n);
    repeat (7) tick();
    #3 rst_n = 1'b0;
    #1;
    check("midscan_rst_seg", 32'(seg), 32'hFF);
    check("midscan_rst_sel", 32'(digit_sel), 32'hFF);
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(u_if.load_ready), 32'd1);
    check("post_rst_frame_done", 32'(frame_done), 32'd0);

    push_frame(W5_SEG, 0, 7);
    offer(32'h00000105, 8'h00);
    tick();
    u_if.load_valid = 1'b0;
    enable = 1'b1;
    wait_fd(n);
    enable = 1'b0;
    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed seven-segment display driver for the board's NUM_DIGITS-digit hex display. It consumes the one-hot digit-select convention produced by the team's onehot decoders and drives the display directly. Upstream logic loads a packed hex word through a valid/ready handshake. The block double-buffers that word, scans the digits with a prescaled refresh and a dead-time gap, and commits new data only at frame boundaries so the display never tears.

Parameters:
NUM_DIGITS, 8, number of digits; power of two, 2..8.
PRESCALE, 50000, clk cycles each digit is lit; must be >= 1.
DEAD_CYCLES, 2, blank cycles between digits for anti-ghosting; 0 disables the gap.
ACTIVE_LOW_SEG, 1, when 1, seg and digit_sel are inverted at the pins.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  scan enable; low blanks the display.
load_valid  in  1  upstream offers load_data/load_dp.
load_ready  out  1  block can accept a load.
load_data  in  4*NUM_DIGITS  packed nibbles; digit i = [4i+3:4i]; digit 0 is rightmost.
load_dp  in  NUM_DIGITS  decimal point per digit.
digit_sel  out  NUM_DIGITS  one-hot digit strobe; polarity per ACTIVE_LOW_SEG.
seg  out  8  {dp,g,f,e,d,c,b,a}; polarity per ACTIVE_LOW_SEG.
frame_done  out  1  one-cycle pulse when the last digit's slot completes.

Behaviour:
- The interface uses one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - digit_sel and seg are inactive (all 1s if ACTIVE_LOW_SEG, else all 0s).
  - load_ready=1, frame_done=0.
  - Active and pending buffers are cleared, the pending flag is clear, idx=0, counter=0, state=OFF.
- All outputs are registered. Polarity inversion is the final stage.
- State machine (OFF / ON / GAP):
  - OFF: outputs inactive; counter and idx held at 0. If enable=1, go to ON next cycle.
  - ON: digit_sel=onehot(idx); seg=hex(active nibble idx) plus dp. Stays PRESCALE cycles. Then go to GAP, or to the next ON if DEAD_CYCLES=0.
  - GAP: digit_sel inactive, seg inactive for DEAD_CYCLES cycles. Then idx=idx+1 mod NUM_DIGITS and go to ON.
  - Any state: enable=0 sends the block to OFF on the next cycle. A partial frame is abandoned with no frame_done, idx resets to 0, and pending data is retained.
- Frame boundary: the cycle the last slot of idx=NUM_DIGITS-1 ends (last GAP cycle, or last ON cycle if DEAD_CYCLES=0).
  - frame_done=1 for exactly that cycle.
  - If pending is valid, pending is copied to active and cleared; load_ready returns to 1 the next cycle.
- Handshake: a transfer occurs on load_valid && load_ready at a rising edge.
  - In ON/GAP, the data goes to pending and load_ready=0 from the next cycle until commit.
  - In OFF, the data goes straight to active and load_ready stays 1. Any pending word is also committed immediately on the first OFF cycle.
  - A transfer in the same cycle as the frame boundary with pending empty bypasses to active. load_ready stays 1.
  - load_valid while load_ready=0 is ignored; upstream must hold its data.
- Hex map (active-high, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71.
- Counter width is clog2(max(PRESCALE,DEAD_CYCLES)+1) and saturates to reload without overflow. idx is a clog2(NUM_DIGITS)-bit counter that wraps naturally.

Optional Feature:
Macro SEG_LEADING_ZERO_BLANK_EN.
- Defined: during ON, a digit whose nibble and all higher nibbles are 0 gets a blank segment pattern, but its dp is still shown. digit_sel is still strobed so timing is unchanged. Digit 0 is never blanked.
- Undefined: every digit shows its nibble. No extra logic is generated.

Decomposition:
- Package seg_pkg holds:
  - state encoding localparams (OFF, ON, GAP);
  - the 16-entry hex-to-segment constant;
  - the SEG_OFF constant;
  - a clog2 helper function.
- One sub-module, seg7_hex_decode: 4-bit nibble plus blank input to a 7-bit active-high pattern, purely combinational. Polarity inversion stays in seg_scan_driver.

Test Plan:
- Reset: assert rst_n=0 mid-scan -> outputs go inactive immediately (seg=FF, digit_sel=FF with ACTIVE_LOW_SEG=1); after release, load_ready=1 and frame_done=0.
- Basic scan, with PRESCALE=4, DEAD_CYCLES=1, enable=1, load 0x12345678 while OFF:
  - digit 0 lit with seg=0x80 (8, active-low) for 4 cycles, then 1 blank cycle;
  - digit 1 shows 7 (0xF8);
  - frame_done pulses every 40 cycles.
- Tear-free update: load 0xAAAAAAAA mid-frame -> load_ready=0 next cycle; the display keeps the old digits until frame_done, then shows A (0x88) from digit 0. load_ready=1 after commit.
- Backpressure: second load_valid while load_ready=0 -> ignored; the first word is displayed and the second is accepted only after commit.
- Boundary bypass: transfer coinciding with frame_done, pending empty -> the new word is shown on digit 0 of the next frame and load_ready never drops.
- enable drop mid-frame at idx=3 -> outputs inactive next cycle, no frame_done; re-enable -> scan restarts at digit 0 with pending committed. With SEG_LEADING_ZERO_BLANK_EN, load 0x00000105 -> digits 7..3 blank, digit 2 shows 1, digit 1 shows 0.
